mem_word_transfer_unit: RTL and testbench
=========================================

// Module: mem_word_transfer_unit
// PURPOSE
//  Sequences multi-byte word transfers between the datapath and the byte-wide Memory.
//  It replaces ad-hoc byte-lane muxing and per-byte DR/IR loads with one handshake.
//  Write: serialises 1..BEATS bytes of a DATA_W word into consecutive addresses.
//  Read: assembles 1..BEATS bytes into a DATA_W word, zero- or sign-extended.
//  Sits between ALUOut/OutD and the Memory; the control unit issues one Start per word.
// PARAMETERS
//  DATA_W     32  word width; must be a multiple of MEM_W and at least 2*MEM_W
//  MEM_W       8  memory data width (one beat)
//  ADDR_W     16  memory address width
//  BIG_ENDIAN  0  0: least-significant byte at lowest address; 1: most-significant byte first
//  derived: BEATS = DATA_W/MEM_W; SZ_W = $clog2(BEATS)
// PORTS
//  Clock        in   1       rising-edge clock
//  Reset        in   1       asynchronous, active-high reset
//  Start        in   1       request; sampled only in IDLE
//  Dir          in   1       0 = read, 1 = write
//  Size         in   SZ_W    number of bytes minus 1 (0..BEATS-1)
//  SignExt      in   1       read only: sign-extend the assembled word
//  Addr         in   ADDR_W  base byte address
//  WData        in   DATA_W  write word; only bytes 0..Size are used
//  RData        out  DATA_W  assembled read word; held until the next accepted read
//  Busy         out  1       high in XFER and DONE
//  Done         out  1       one-cycle pulse in DONE
//  Mem_Address  out  ADDR_W  memory address
//  Mem_Data     out  MEM_W   memory write data
//  Mem_In       in   MEM_W   memory read data (combinational, same cycle)
//  Mem_WR       out  1       1 = write, 0 = read
//  Mem_CS       out  1       active-low chip select
// BEHAVIOUR
//  Reset values: RData=0, Busy=0, Done=0, Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0; FSM in IDLE.
//  FSM states IDLE -> XFER -> DONE -> IDLE.
//  IDLE:
//   - Start=1 at a posedge: capture Addr, WData, Dir, Size and SignExt; clear beat counter b; go to XFER.
//   - Start is ignored in XFER and DONE. There is no queueing.
//  XFER (one beat per cycle, b = 0..Size):
//   - Mem_CS=0, Mem_WR=Dir, Mem_Address = (Addr + b) mod 2^ADDR_W.
//   - Address wraps silently from all-ones to 0.
//   - Lane L = b when BIG_ENDIAN=0; L = Size-b when BIG_ENDIAN=1.
//   - Write: Mem_Data = WData[L*MEM_W +: MEM_W].
//   - Read: at the posedge, Mem_In is stored into lane L of the assembly register.
//   - When b == Size at a posedge, go to DONE. Otherwise b increments.
//  DONE (one cycle):
//   - Done=1, Mem_CS=1, Mem_WR=0.
//   - A read updates RData: lanes 0..Size from the assembly register; upper lanes take
//     bit ((Size+1)*MEM_W-1) when SignExt=1, else 0.
//   - A write leaves RData unchanged.
//   - Next state is IDLE. A Start seen during DONE is ignored; a Start held high is accepted in the following IDLE cycle.
//  Latency: Start accepted at edge k -> beats in cycles k+1..k+1+Size -> Done in cycle k+2+Size.
//   Back-to-back transfers: one request every Size+3 cycles.
//  Outside XFER: Mem_CS=1, Mem_WR=0, Mem_Address=0, Mem_Data=0. Memory is never selected while idle.
//  Size is decoded as an unsigned value; every value 0..BEATS-1 is legal, so no error case exists.
//  Reset mid-transfer:
//   - Immediate return to IDLE, Mem_CS=1, Busy=0, no Done pulse.
//   - Bytes already written stay written; a partial read is discarded and RData=0.
//  All outputs are registered or decoded from the registered state only. No Start-to-memory combinational path.
// TESTING
//  T1: Assert Reset mid-idle and mid-XFER -> all outputs at their reset values in the same cycle; Mem_CS=1.
//  T2: Write, Addr=0x0100, WData=0xDEADBEEF, Size=3 -> EF@0100, BE@0101, AD@0102, DE@0103
//      in cycles k+1..k+4; Done at k+5; Busy low at k+6.
//  T3: Read, mem[0x0200]=0x34, mem[0x0201]=0x92, Size=1 -> SignExt=1: RData=0xFFFF9234;
//      SignExt=0: RData=0x00009234.
//  T4: Write, Addr=0xFFFE, Size=3 -> addresses FFFE, FFFF, 0000, 0001 in order.
//      Start pulses during XFER and DONE are ignored.
//  T5: BIG_ENDIAN=1 instance, write 0x11223344 to 0x0040 -> 11@40, 22@41, 33@42, 44@43;
//      a read-back returns 0x11223344.
//  T6: Reset asserted after 2 write beats of a Size=3 write -> only 2 bytes modified; no Done;
//      the next Start completes normally.

Source files
------------

// File: rtl/mem_word_transfer_unit.sv
// Sequences one multi-byte word transfer per Start over a byte-wide memory port.
// Writes serialise lanes to consecutive addresses; reads assemble lanes and zero/sign-extend.
module mem_word_transfer_unit #(
  parameter int DATA_W     = 32,
  parameter int MEM_W      = 8,
  parameter int ADDR_W     = 16,
  parameter int BIG_ENDIAN = 0,
  localparam int BEATS     = DATA_W / MEM_W,
  localparam int SZ_W      = $clog2(BEATS)
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Dir,
  input  logic [SZ_W-1:0]   Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [MEM_W-1:0]  Mem_Data,
  input  logic [MEM_W-1:0]  Mem_In,
  output logic              Mem_WR,
  output logic              Mem_CS
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_next;
  logic [DATA_W-1:0] ext_word;
  logic              dir_q;
  logic              sext_q;
  logic [SZ_W-1:0]   size_q;
  logic [SZ_W-1:0]   beat;
  logic [SZ_W-1:0]   lane;
  logic [MEM_W-1:0]  lane_byte;
  logic              sign_bit;
  logic              last_beat;
  logic              in_xfer;

  // State register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (Start) next_state = XFER;
        else       next_state = IDLE;
      end
      XFER: begin
        if (last_beat) next_state = DONE;
        else           next_state = XFER;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign in_xfer   = (state == XFER);
  assign last_beat = (beat == size_q);
  assign lane      = (BIG_ENDIAN != 0) ? (size_q - beat) : beat;

  // Lane steering: write byte select, read assembly and extension of the finished word
  always_comb begin
    asm_next  = asm_q;
    lane_byte = '0;
    sign_bit  = 1'b0;
    ext_word  = '0;
    for (int i = 0; i < BEATS; i++) begin
      asm_next[i*MEM_W +: MEM_W] = (SZ_W'(i) == lane) ? Mem_In : asm_q[i*MEM_W +: MEM_W];
      lane_byte = lane_byte | ((SZ_W'(i) == lane) ? wdata_q[i*MEM_W +: MEM_W] : {MEM_W{1'b0}});
    end
    // The top used lane supplies the sign when extension is requested
    for (int i = 0; i < BEATS; i++) begin
      sign_bit = sign_bit | ((SZ_W'(i) == size_q) ? (sext_q & asm_next[i*MEM_W + MEM_W - 1]) : 1'b0);
    end
    for (int i = 0; i < BEATS; i++) begin
      ext_word[i*MEM_W +: MEM_W] = (SZ_W'(i) <= size_q) ? asm_next[i*MEM_W +: MEM_W]
                                                          : {MEM_W{sign_bit}};
    end
  end

  // Request capture, beat counting, read assembly and RData update on the final beat
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      dir_q   <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      beat    <= '0;
      asm_q   <= '0;
      RData   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            addr_q  <= Addr;
            wdata_q <= WData;
            dir_q   <= Dir;
            sext_q  <= SignExt;
            size_q  <= Size;
            beat    <= '0;
            asm_q   <= '0;
          end
        end
        XFER: begin
          if (!dir_q) asm_q <= asm_next;
          if (last_beat) begin
            if (!dir_q) RData <= ext_word;
          end else begin
            beat <= beat + SZ_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory side is decoded purely from registered state, so Start never reaches it directly
  assign Mem_CS      = ~in_xfer;
  assign Mem_WR      = in_xfer & dir_q;
  assign Mem_Address = in_xfer ? (addr_q + ADDR_W'(beat)) : {ADDR_W{1'b0}};
  assign Mem_Data    = (in_xfer && dir_q) ? lane_byte : {MEM_W{1'b0}};
  assign Busy        = (state != IDLE);
  assign Done        = (state == DONE);

endmodule

// File: tb/tb_mem_word_transfer_unit.sv
// Drives a little-endian and a big-endian instance with identical requests and checks
// bus activity, memory contents and RData against a byte-array reference model.
module tb_mem_word_transfer_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dir = 1'b0;
  logic        sext = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [15:0] addr = 16'h0000;
  logic [31:0] wdata = 32'h0;

  logic [31:0] rdata_le, rdata_be;
  logic        busy_le, busy_be, done_le, done_be;
  logic [15:0] ma_le, ma_be;
  logic [7:0]  md_le, md_be, mi_le, mi_be;
  logic        wr_le, wr_be, cs_le, cs_be;

  logic [7:0]  mem_le [0:65535];
  logic [7:0]  mem_be [0:65535];
  logic [7:0]  ref_le [0:65535];
  logic [7:0]  ref_be [0:65535];
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0;
  logic [7:0]  pre_data = 8'h0;

  logic [31:0] exp_le = 32'h0;
  logic [31:0] exp_be = 32'h0;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  mem_word_transfer_unit #(.DATA_W(32), .MEM_W(8), .ADDR_W(16), .BIG_ENDIAN(0)) dut_le (
    .Clock(clk), .Reset(rst), .Start(start), .Dir(dir), .Size(size), .SignExt(sext),
    .Addr(addr), .WData(wdata), .RData(rdata_le), .Busy(busy_le), .Done(done_le),
    .Mem_Address(ma_le), .Mem_Data(md_le), .Mem_In(mi_le), .Mem_WR(wr_le), .Mem_CS(cs_le));

  mem_word_transfer_unit #(.DATA_W(32), .MEM_W(8), .ADDR_W(16), .BIG_ENDIAN(1)) dut_be (
    .Clock(clk), .Reset(rst), .Start(start), .Dir(dir), .Size(size), .SignExt(sext),
    .Addr(addr), .WData(wdata), .RData(rdata_be), .Busy(busy_be), .Done(done_be),
    .Mem_Address(ma_be), .Mem_Data(md_be), .Mem_In(mi_be), .Mem_WR(wr_be), .Mem_CS(cs_be));

  assign mi_le = mem_le[ma_le];
  assign mi_be = mem_be[ma_be];

  // Byte-wide memories behind each instance, plus a bench-side preload port
  always @(posedge clk) begin
    if (pre_we) begin
      mem_le[pre_addr] <= pre_data;
      mem_be[pre_addr] <= pre_data;
    end else begin
      if (!cs_le && wr_le) mem_le[ma_le] <= md_le;
      if (!cs_be && wr_be) mem_be[ma_be] <= md_be;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zero- or sign-extend the low (sz+1) bytes of w
  function automatic logic [31:0] extend(input logic [31:0] w, input int sz, input logic se);
    logic [63:0] v;
    logic [63:0] mask;
    int nb;
    nb   = 8 * (sz + 1);
    mask = (64'd1 << nb) - 64'd1;
    v    = {32'h0, w} & mask;
    if (se && (((v >> (nb - 1)) & 64'd1) != 64'd0)) v = v | ~mask;
    return v[31:0];
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_rdata_le"}, rdata_le, 32'h0);
    check({tag, "_rdata_be"}, rdata_be, 32'h0);
    check({tag, "_busy"}, {busy_le, busy_be}, 2'b00);
    check({tag, "_done"}, {done_le, done_be}, 2'b00);
    check({tag, "_cs"}, {cs_le, cs_be}, 2'b11);
    check({tag, "_wr"}, {wr_le, wr_be}, 2'b00);
    check({tag, "_addr"}, {ma_le, ma_be}, 32'h0);
    check({tag, "_data"}, {md_le, md_be}, 16'h0);
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_le[a] = d;
    ref_be[a] = d;
  endtask

  task automatic memcmp(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] x;
      x = a + 16'(i);
      check("mem_le", mem_le[x], ref_le[x]);
      check("mem_be", mem_be[x], ref_be[x]);
    end
  endtask

  // One complete request; with noise=1 Start stays high through XFER and DONE
  task automatic xfer(input logic d, input logic [1:0] sz, input logic se,
                      input logic [15:0] a, input logic [31:0] wd, input logic noise);
    logic [31:0] word_le, word_be;
    logic [15:0] ea;
    int          bl;
    word_le = 32'h0;
    word_be = 32'h0;
    @(negedge clk);
    start = 1'b1; dir = d; size = sz; sext = se; addr = a; wdata = wd;
    @(posedge clk); #1;
    start = noise; dir = ~d; size = ~sz; sext = ~se; addr = ~a; wdata = ~wd;
    for (int b = 0; b <= int'(sz); b++) begin
      ea = a + 16'(b);
      bl = int'(sz) - b;
      check("beat_cs", {cs_le, cs_be}, 2'b00);
      check("beat_busy", {busy_le, busy_be}, 2'b11);
      check("beat_addr_le", ma_le, ea);
      check("beat_addr_be", ma_be, ea);
      check("beat_wr", {wr_le, wr_be}, {d, d});
      if (d) begin
        check("beat_data_le", md_le, 8'(wd >> (8 * b)));
        check("beat_data_be", md_be, 8'(wd >> (8 * bl)));
        ref_le[ea] = 8'(wd >> (8 * b));
        ref_be[ea] = 8'(wd >> (8 * bl));
      end else begin
        word_le = word_le | ({24'h0, ref_le[ea]} << (8 * b));
        word_be = word_be | ({24'h0, ref_be[ea]} << (8 * bl));
      end
      @(posedge clk); #1;
    end
    check("done_pulse", {done_le, done_be}, 2'b11);
    check("done_busy", {busy_le, busy_be}, 2'b11);
    check("done_cs", {cs_le, cs_be}, 2'b11);
    check("done_wr", {wr_le, wr_be}, 2'b00);
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_done", {done_le, done_be}, 2'b00);
    check("idle_busy", {busy_le, busy_be}, 2'b00);
    if (!d) begin
      exp_le = extend(word_le, int'(sz), se);
      exp_be = extend(word_be, int'(sz), se);
    end
    check("rdata_le", rdata_le, exp_le);
    check("rdata_be", rdata_be, exp_be);
    if (noise) begin
      @(posedge clk); #1;
      check("ignored_start_busy", {busy_le, busy_be}, 2'b00);
    end
  endtask

  initial begin
    logic [15:0] ra;
    logic [1:0]  rs;
    logic [31:0] rw;

    // Reset held from time zero: checked mid-cycle
    #12;
    check_reset("rst_init");
    @(negedge clk);
    rst = 1'b0;

    // Plain four-byte write
    xfer(1'b1, 2'd3, 1'b0, 16'h0100, 32'hDEADBEEF, 1'b0);
    check("t2_0100", mem_le[16'h0100], 8'hEF);
    check("t2_0101", mem_le[16'h0101], 8'hBE);
    check("t2_0102", mem_le[16'h0102], 8'hAD);
    check("t2_0103", mem_le[16'h0103], 8'hDE);
    memcmp(16'h0100, 4);

    // Two-byte read with and without sign extension
    preload(16'h0200, 8'h34);
    preload(16'h0201, 8'h92);
    xfer(1'b0, 2'd1, 1'b1, 16'h0200, 32'h0, 1'b0);
    check("t3_sext", rdata_le, 32'hFFFF9234);
    xfer(1'b0, 2'd1, 1'b0, 16'h0200, 32'h0, 1'b0);
    check("t3_zext", rdata_le, 32'h00009234);

    // Reset while idle clears the held RData
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("rst_idle");
    exp_le = 32'h0;
    exp_be = 32'h0;
    @(negedge clk);
    rst = 1'b0;

    // Address wrap, with Start held high through the transfer
    xfer(1'b1, 2'd3, 1'b0, 16'hFFFE, 32'hCAFEF00D, 1'b1);
    memcmp(16'hFFFE, 4);
    xfer(1'b0, 2'd3, 1'b1, 16'hFFFE, 32'h0, 1'b1);

    // Big-endian lane order and read-back
    xfer(1'b1, 2'd3, 1'b0, 16'h0040, 32'h11223344, 1'b0);
    check("t5_40", mem_be[16'h0040], 8'h11);
    check("t5_41", mem_be[16'h0041], 8'h22);
    check("t5_42", mem_be[16'h0042], 8'h33);
    check("t5_43", mem_be[16'h0043], 8'h44);
    xfer(1'b0, 2'd3, 1'b0, 16'h0040, 32'h0, 1'b0);
    check("t5_readback", rdata_be, 32'h11223344);

    // Reset after two beats of a four-byte write
    xfer(1'b1, 2'd3, 1'b0, 16'h0300, 32'h55667788, 1'b0);
    @(negedge clk);
    start = 1'b1; dir = 1'b1; size = 2'd3; sext = 1'b0; addr = 16'h0300; wdata = 32'hA1B2C3D4;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      ref_le[16'h0300 + 16'(b)] = 8'(32'hA1B2C3D4 >> (8 * b));
      ref_be[16'h0300 + 16'(b)] = 8'(32'hA1B2C3D4 >> (8 * (3 - b)));
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    check_reset("rst_xfer");
    exp_le = 32'h0;
    exp_be = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("t6_no_done", {done_le, done_be, busy_le, busy_be}, 4'b0000);
    end
    memcmp(16'h0300, 4);
    check("t6_0301", mem_le[16'h0301], 8'hC3);
    check("t6_0302", mem_le[16'h0302], 8'h66);
    xfer(1'b1, 2'd3, 1'b0, 16'h0300, 32'h0BADC0DE, 1'b0);
    memcmp(16'h0300, 4);
    xfer(1'b0, 2'd3, 1'b0, 16'h0300, 32'h0, 1'b0);

    // Random write/read-back pairs
    repeat (24) begin
      ra = 16'($urandom);
      rs = 2'($urandom_range(0, 3));
      rw = $urandom;
      xfer(1'b1, rs, 1'b0, ra, rw, 1'($urandom));
      memcmp(ra, int'(rs) + 1);
      xfer(1'b0, 2'($urandom_range(0, int'(rs))), 1'($urandom), ra, $urandom, 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
